// File: rtl/lb_window_ctrl.sv
`timescale 1ns/1ps
// Sequencer for the 3-row line-buffer chain feeding the 3x3 window datapath.
// Define LB_CTRL_FLUSH_EN to inject end-of-frame flush beats for the final row/column.
module lb_window_ctrl #(
  parameter int unsigned IMG_WIDTH  = 1280,
  parameter int unsigned IMG_HEIGHT = 720,
  parameter int unsigned CW         = 11,
  parameter int unsigned RW         = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          valid_in,
  output logic          in_ready,
  output logic          lb_valid,
  output logic          lb_flush,
  output logic          win_valid,
  output logic [CW-1:0] win_col,
  output logic [RW-1:0] win_row,
  output logic          edge_top,
  output logic          edge_bot,
  output logic          edge_left,
  output logic          edge_right,
  output logic          frame_done,
  output logic          err_abort
);

  localparam int unsigned   LW        = CW + 1;
  localparam logic [CW-1:0] LastCol   = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LastRow   = RW'(IMG_HEIGHT - 1);
  localparam logic [LW-1:0] LeadBeats = LW'(IMG_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] in_col_q, in_col_d, cen_col_q, cen_col_d, win_col_q, win_col_d;
  logic [RW-1:0] in_row_q, in_row_d, cen_row_q, cen_row_d, win_row_q, win_row_d;
  logic [LW-1:0] lead_q, lead_d;
  logic          win_valid_q, win_valid_d;
  logic          edge_top_q, edge_top_d, edge_bot_q, edge_bot_d;
  logic          edge_left_q, edge_left_d, edge_right_q, edge_right_d;
  logic          frame_done_q, frame_done_d, err_abort_q, err_abort_d;
  logic          accept, flush_beat, beat, centre, last_in;
`ifdef LB_CTRL_FLUSH_EN
  logic [LW-1:0] flush_cnt_q, flush_cnt_d;
`endif

  assign in_ready = (state_q == StRun);
`ifdef LB_CTRL_FLUSH_EN
  assign flush_beat = (state_q == StFlush);
`else
  assign flush_beat = 1'b0;
`endif
  assign accept   = valid_in & in_ready;
  assign beat     = accept | flush_beat;
  // The centre trails the stream by one line plus one pixel.
  assign centre   = beat & (lead_q == LeadBeats);
  assign last_in  = (in_col_q == LastCol) && (in_row_q == LastRow);
  assign lb_valid = beat;
  assign lb_flush = flush_beat;

  always_comb begin
    state_d      = state_q;
    in_col_d     = in_col_q;
    in_row_d     = in_row_q;
    cen_col_d    = cen_col_q;
    cen_row_d    = cen_row_q;
    lead_d       = lead_q;
    win_valid_d  = centre;
    win_col_d    = centre ? cen_col_q : win_col_q;
    win_row_d    = centre ? cen_row_q : win_row_q;
    edge_top_d   = centre ? (cen_row_q == '0) : edge_top_q;
    edge_bot_d   = centre ? (cen_row_q == LastRow) : edge_bot_q;
    edge_left_d  = centre ? (cen_col_q == '0) : edge_left_q;
    edge_right_d = centre ? (cen_col_q == LastCol) : edge_right_q;
    frame_done_d = (state_q == StDone);
    err_abort_d  = frame_start & ((state_q == StRun) | (state_q == StFlush));
`ifdef LB_CTRL_FLUSH_EN
    flush_cnt_d  = flush_cnt_q;
`endif

    unique case (state_q)
      StIdle: ;
      StRun: begin
        if (accept) begin
          if (last_in) begin
`ifdef LB_CTRL_FLUSH_EN
            state_d = StFlush;
`else
            state_d = StDone;
`endif
          end else if (in_col_q == LastCol) begin
            in_col_d = '0;
            in_row_d = in_row_q + RW'(1);
          end else begin
            in_col_d = in_col_q + CW'(1);
          end
        end
      end
      StFlush: begin
`ifdef LB_CTRL_FLUSH_EN
        flush_cnt_d = flush_cnt_q + LW'(1);
        if (flush_cnt_q == LW'(IMG_WIDTH)) state_d = StDone;
`else
        state_d = StIdle;
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (beat && !centre) lead_d = lead_q + LW'(1);

    // Centre counters saturate on the last centre instead of wrapping.
    if (centre) begin
      if (cen_col_q != LastCol) begin
        cen_col_d = cen_col_q + CW'(1);
      end else if (cen_row_q != LastRow) begin
        cen_col_d = '0;
        cen_row_d = cen_row_q + RW'(1);
      end
    end

    // A new frame overrides everything, including a beat in the same cycle.
    if (frame_start) begin
      state_d     = StRun;
      in_col_d    = '0;
      in_row_d    = '0;
      cen_col_d   = '0;
      cen_row_d   = '0;
      lead_d      = '0;
      win_valid_d = 1'b0;
`ifdef LB_CTRL_FLUSH_EN
      flush_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      in_col_q     <= '0;
      in_row_q     <= '0;
      cen_col_q    <= '0;
      cen_row_q    <= '0;
      lead_q       <= '0;
      win_valid_q  <= 1'b0;
      win_col_q    <= '0;
      win_row_q    <= '0;
      edge_top_q   <= 1'b0;
      edge_bot_q   <= 1'b0;
      edge_left_q  <= 1'b0;
      edge_right_q <= 1'b0;
      frame_done_q <= 1'b0;
      err_abort_q  <= 1'b0;
`ifdef LB_CTRL_FLUSH_EN
      flush_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      cen_col_q    <= cen_col_d;
      cen_row_q    <= cen_row_d;
      lead_q       <= lead_d;
      win_valid_q  <= win_valid_d;
      win_col_q    <= win_col_d;
      win_row_q    <= win_row_d;
      edge_top_q   <= edge_top_d;
      edge_bot_q   <= edge_bot_d;
      edge_left_q  <= edge_left_d;
      edge_right_q <= edge_right_d;
      frame_done_q <= frame_done_d;
      err_abort_q  <= err_abort_d;
`ifdef LB_CTRL_FLUSH_EN
      flush_cnt_q  <= flush_cnt_d;
`endif
    end
  end

  assign win_valid  = win_valid_q;
  assign win_col    = win_col_q;
  assign win_row    = win_row_q;
  assign edge_top   = edge_top_q;
  assign edge_bot   = edge_bot_q;
  assign edge_left  = edge_left_q;
  assign edge_right = edge_right_q;
  assign frame_done = frame_done_q;
  assign err_abort  = err_abort_q;

endmodule

// File: tb/tb_lb_window_ctrl.sv
`timescale 1ns/1ps
// Directed bench for lb_window_ctrl on a 4x3 image; adapts to LB_CTRL_FLUSH_EN.
module tb_lb_window_ctrl;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CW = 3;
  localparam int RW = 2;
`ifdef LB_CTRL_FLUSH_EN
  localparam bit FlushEn = 1'b1;
`else
  localparam bit FlushEn = 1'b0;
`endif
  localparam int NCen     = FlushEn ? W * H : W * H - (W + 1);
  localparam int FrameLen = FlushEn ? 1 + W * H + (W + 1) + 1 : 1 + W * H + 1;

  logic          clk, rst_n, frame_start, valid_in;
  logic          in_ready, lb_valid, lb_flush, win_valid;
  logic [CW-1:0] win_col;
  logic [RW-1:0] win_row;
  logic          edge_top, edge_bot, edge_left, edge_right, frame_done, err_abort;

  lb_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CW(CW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .valid_in(valid_in),
    .in_ready(in_ready), .lb_valid(lb_valid), .lb_flush(lb_flush), .win_valid(win_valid),
    .win_col(win_col), .win_row(win_row), .edge_top(edge_top), .edge_bot(edge_bot),
    .edge_left(edge_left), .edge_right(edge_right), .frame_done(frame_done),
    .err_abort(err_abort)
  );

  always #5 clk = ~clk;

  int tot = 0, bad = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  int n_win = 0, n_flush = 0, n_ready = 0, n_lbv = 0, n_done = 0, n_abort = 0, n_orphan = 0;
  int cen_cyc [32];
  logic [8:0] cen_pos [32];
  logic prev_lbv = 1'b0;

  // Sampled mid-cycle; win_valid must always follow a stream beat.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (win_valid) begin
      if (!prev_lbv) n_orphan++;
      if (n_win < 32) begin
        cen_pos[n_win] = {win_row, win_col, edge_top, edge_bot, edge_left, edge_right};
        cen_cyc[n_win] = cyc;
      end
      n_win++;
    end
    if (lb_flush) n_flush++;
    if (lb_valid) n_lbv++;
    if (in_ready) n_ready++;
    if (err_abort) n_abort++;
    if (frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
    prev_lbv = lb_valid;
  end

  function automatic logic [8:0] exp_pos(input int i);
    int r, c;
    r = i / W;
    c = i % W;
    return {RW'(r), CW'(c), r == 0, r == H - 1, c == 0, c == W - 1};
  endfunction

  task automatic clr_mon();
    n_win = 0; n_flush = 0; n_ready = 0; n_lbv = 0; n_done = 0; n_abort = 0; n_orphan = 0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input bit bubbles, input int nbeats);
    int sent = 0;
    int guard = 0;
    bit ph = 1'b1;
    start_cyc = cyc + 1;
    frame_start = 1'b1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    frame_start = 1'b0;
    while (sent < nbeats && guard < 100) begin
      valid_in = bubbles ? ph : 1'b1;
      ph = ~ph;
      #2;
      if (valid_in && in_ready) sent++;
      @(posedge clk); #1;
      guard++;
    end
    valid_in = 1'b0;
    tot++;
    if (sent != nbeats) begin
      bad++;
      $display("FAIL beats_accepted got=%0d want=%0d", sent, nbeats);
    end
  endtask

  task automatic test_reset();
    #1;
    tot++;
    if ({in_ready, lb_valid, lb_flush, win_valid, win_col, win_row, edge_top, edge_bot,
         edge_left, edge_right, frame_done, err_abort} !== 15'b0) begin
      bad++;
      $display("FAIL reset_outputs in_ready=%b lb_valid=%b win_valid=%b want all 0",
               in_ready, lb_valid, win_valid);
    end
    settle(2);
    rst_n = 1'b1;
    settle(1);
    tot++;
    if ({in_ready, lb_valid, win_valid, frame_done} !== 4'b0) begin
      bad++;
      $display("FAIL post_reset_idle got=%b want=0000", {in_ready, lb_valid, win_valid, frame_done});
    end
  endtask

  task automatic test_idle_input();
    clr_mon();
    valid_in = 1'b1;
    settle(5);
    valid_in = 1'b0;
    tot++;
    if (n_ready != 0 || n_lbv != 0 || n_win != 0) begin
      bad++;
      $display("FAIL idle_input ready=%0d lbv=%0d win=%0d want 0 0 0", n_ready, n_lbv, n_win);
    end
  endtask

  task automatic check_seq(input string name, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      tot++;
      if (cen_pos[base + i] !== exp_pos(i)) begin
        bad++;
        $display("FAIL %s centre[%0d] got=%h want=%h", name, i, cen_pos[base + i], exp_pos(i));
      end
    end
  endtask

  task automatic test_full_rate();
    clr_mon();
    drive_frame(1'b0, W * H);
    settle(30);
    tot++;
    if (n_win != NCen) begin
      bad++; $display("FAIL full_win_count got=%0d want=%0d", n_win, NCen);
    end
    check_seq("full", 0, NCen);
    tot++;
    if (n_ready != W * H) begin
      bad++; $display("FAIL full_in_ready_cycles got=%0d want=%0d", n_ready, W * H);
    end
    tot++;
    if (n_flush != (FlushEn ? W + 1 : 0)) begin
      bad++; $display("FAIL full_flush_beats got=%0d want=%0d", n_flush, FlushEn ? W + 1 : 0);
    end
    tot++;
    if (n_lbv != W * H + (FlushEn ? W + 1 : 0)) begin
      bad++; $display("FAIL full_lb_valid_beats got=%0d", n_lbv);
    end
    // Beat 5 lands at start+6, its centre one cycle later.
    tot++;
    if (cen_cyc[0] != start_cyc + 7) begin
      bad++; $display("FAIL full_first_centre_cycle got=%0d want=%0d", cen_cyc[0], start_cyc + 7);
    end
    tot++;
    if (n_done != 1 || done_cyc != cen_cyc[NCen-1] + 1) begin
      bad++;
      $display("FAIL full_frame_done count=%0d cyc=%0d want 1 at %0d", n_done, done_cyc,
               cen_cyc[NCen-1] + 1);
    end
    tot++;
    if (done_cyc - start_cyc != FrameLen) begin
      bad++; $display("FAIL full_frame_len got=%0d want=%0d", done_cyc - start_cyc, FrameLen);
    end
    tot++;
    if (n_orphan != 0 || n_abort != 0) begin
      bad++; $display("FAIL full_spurious orphan=%0d abort=%0d want 0 0", n_orphan, n_abort);
    end
  endtask

  task automatic test_bubbles();
    clr_mon();
    drive_frame(1'b1, W * H);
    settle(30);
    tot++;
    if (n_win != NCen) begin
      bad++; $display("FAIL bubble_win_count got=%0d want=%0d", n_win, NCen);
    end
    check_seq("bubble", 0, NCen);
    tot++;
    if (n_orphan != 0 || n_done != 1) begin
      bad++; $display("FAIL bubble_timing orphan=%0d done=%0d want 0 1", n_orphan, n_done);
    end
  endtask

  task automatic test_abort();
    clr_mon();
    drive_frame(1'b0, 7);
    drive_frame(1'b0, W * H);
    settle(30);
    tot++;
    if (n_abort != 1 || n_done != 1) begin
      bad++; $display("FAIL abort_pulses abort=%0d done=%0d want 1 1", n_abort, n_done);
    end
    tot++;
    if (n_win != 2 + NCen) begin
      bad++; $display("FAIL abort_win_count got=%0d want=%0d", n_win, 2 + NCen);
    end
    check_seq("abort_old", 0, 2);
    check_seq("abort_new", 2, NCen);
  endtask

  task automatic test_reset_mid_frame();
    clr_mon();
`ifdef LB_CTRL_FLUSH_EN
    drive_frame(1'b0, W * H);
    settle(2);
    tot++;
    if (lb_flush !== 1'b1) begin
      bad++; $display("FAIL third_flush_beat lb_flush=%b want 1", lb_flush);
    end
`else
    drive_frame(1'b0, 9);
    tot++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_run_ready in_ready=%b want 1", in_ready);
    end
`endif
    rst_n = 1'b0;
    #1;
    tot++;
    if ({in_ready, lb_valid, lb_flush, win_valid, win_col, win_row, edge_top, edge_bot,
         edge_left, edge_right, frame_done, err_abort} !== 15'b0) begin
      bad++;
      $display("FAIL mid_reset_outputs in_ready=%b lb_valid=%b lb_flush=%b want all 0",
               in_ready, lb_valid, lb_flush);
    end
    clr_mon();
    settle(2);
    rst_n = 1'b1;
    valid_in = 1'b1;
    settle(3);
    valid_in = 1'b0;
    tot++;
    if (n_ready != 0 || n_done != 0 || n_win != 0) begin
      bad++;
      $display("FAIL mid_reset_idle ready=%0d done=%0d win=%0d want 0 0 0", n_ready, n_done, n_win);
    end
    clr_mon();
    drive_frame(1'b0, W * H);
    settle(30);
    tot++;
    if (n_win != NCen || n_done != 1) begin
      bad++; $display("FAIL post_reset_frame win=%0d done=%0d want %0d 1", n_win, n_done, NCen);
    end
    check_seq("post_reset", 0, NCen);
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    frame_start = 1'b0;
    valid_in = 1'b0;
    test_reset();
    test_idle_input();
    test_full_rate();
    test_bubbles();
    test_abort();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
